// File: rtl/transpose_sequencer.sv
// Byte-wise matrix transpose sequencer: reads vecSize source rows from the vector
// register file, transposes them combinationally and writes them to a destination block.

module matrix_transpose #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] rows_in,
  output logic [vecSize-1:0][regSize-1:0] rows_out
);

  for (genvar i = 0; i < vecSize; i++) begin : g_row
    for (genvar j = 0; j < vecSize; j++) begin : g_byte
      assign rows_out[i][regSize-1-8*j -: 8] = rows_in[j][regSize-1-8*i -: 8];
    end
  end

endmodule

module transpose_sequencer #(
  parameter int regSize   = 32,
  parameter int vecSize   = 4,
  parameter int addrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addrWidth-1:0] src_base,
  input  logic [addrWidth-1:0] dst_base,
  output logic                 busy,
  output logic                 done,
  output logic                 rf_rd_en,
  output logic [addrWidth-1:0] rf_rd_addr,
  input  logic [regSize-1:0]   rf_rd_data,
  output logic                 rf_wr_en,
  output logic [addrWidth-1:0] rf_wr_addr,
  output logic [regSize-1:0]   rf_wr_data,
  input  logic                 rf_wr_ready
);

  localparam int KW = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [KW-1:0] LAST = KW'(vecSize - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                          state, state_nxt;
  logic [KW-1:0]                   k, k_nxt;
  logic [addrWidth-1:0]            src_q, dst_q;
  logic                            vld_p1;
  logic [KW-1:0]                   idx_p1;
  logic [vecSize-1:0][regSize-1:0] rows_p1;
  logic [vecSize-1:0][regSize-1:0] rows_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      vld_p1  <= 1'b0;
      idx_p1  <= '0;
      rows_p1 <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == S_IDLE && start) begin
        src_q <= src_base;
        dst_q <= dst_base;
      end
      // stage p1: read data returns one cycle after the strobe, tagged with its row
      vld_p1 <= (state == S_READ);
      idx_p1 <= k;
      if (vld_p1) begin
        rows_p1[idx_p1] <= rf_rd_data;
      end
    end
  end

  matrix_transpose #(
    .regSize(regSize),
    .vecSize(vecSize)
  ) u_transpose (
    .rows_in (rows_p1),
    .rows_out(rows_t)
  );

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    busy       = 1'b0;
    done       = 1'b0;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_READ;
          k_nxt     = '0;
        end
      end
      S_READ: begin
        busy       = 1'b1;
        rf_rd_en   = 1'b1;
        rf_rd_addr = src_q + addrWidth'(k);
        if (k == LAST) begin
          state_nxt = S_DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy       = 1'b1;
        rf_wr_en   = 1'b1;
        rf_wr_addr = dst_q + addrWidth'(k);
        rf_wr_data = rows_t[k];
        if (rf_wr_ready) begin
          if (k == LAST) begin
            state_nxt = S_DONE;
            k_nxt     = '0;
          end else begin
            k_nxt = k + KW'(1);
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A reset cycle must not let a pending read or write reach the register file.
    if (rst) begin
      busy       = 1'b0;
      done       = 1'b0;
      rf_rd_en   = 1'b0;
      rf_rd_addr = '0;
      rf_wr_en   = 1'b0;
      rf_wr_addr = '0;
      rf_wr_data = '0;
    end
  end

endmodule

// File: tb/tb_transpose_sequencer.sv
// Directed bench for transpose_sequencer with a small register-file model and
// a monitor that logs accepted reads, writes and done pulses by relative cycle.

module tb_transpose_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  src_base, dst_base;
  logic        busy, done;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data = '0;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_wr_ready;

  transpose_sequencer #(
    .regSize(32),
    .vecSize(4),
    .addrWidth(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .busy       (busy),
    .done       (done),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_ready(rf_wr_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] rows [4] = '{32'h7b5b5465, 32'h73745665, 32'h63746f72, 32'h5d53475d};
  logic [31:0] xpose[4] = '{32'h7b73635d, 32'h5b747453, 32'h54566f47, 32'h6565725d};

  // register file model with a bench-side load port
  logic [31:0] mem [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (rf_wr_en && rf_wr_ready) mem[rf_wr_addr] <= rf_wr_data;
    rf_rd_data <= rf_rd_en ? mem[rf_rd_addr] : 32'h0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = 0;
  logic [3:0]  rd_a [64];
  int          rd_c [64];
  logic [3:0]  wr_a [64];
  logic [31:0] wr_d [64];
  int          wr_c [64];
  int          done_c [64];
  int n_rd = 0, n_wr = 0, n_done = 0, n_overlap = 0;

  always @(negedge clk) begin
    int rel;
    #2;
    rel = cyc - t0 + 1;
    if (rf_rd_en && n_rd < 64) begin
      rd_a[n_rd] = rf_rd_addr;
      rd_c[n_rd] = rel;
      n_rd++;
    end
    if (rf_wr_en && rf_wr_ready && n_wr < 64) begin
      wr_a[n_wr] = rf_wr_addr;
      wr_d[n_wr] = rf_wr_data;
      wr_c[n_wr] = rel;
      n_wr++;
    end
    if (done && n_done < 64) begin
      done_c[n_done] = rel;
      n_done++;
    end
    if (rf_rd_en && rf_wr_en) n_overlap++;
  end

  int n_checks = 0, n_errors = 0;
  int rb, wb, db;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_rows(input logic [3:0] base);
    for (int i = 0; i < 4; i++) load(4'(base + i), rows[i]);
  endtask

  task automatic launch(input logic [3:0] s, input logic [3:0] d);
    @(negedge clk);
    src_base = s; dst_base = d; start = 1'b1;
    rb = n_rd; wb = n_wr; db = n_done;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    src_base = ~s; dst_base = ~d;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 40 && n_done == db; i++) @(negedge clk);
    check({nm, "_done_seen"}, 32'(n_done - db), 32'd1);
  endtask

  task automatic verify(input string nm, input logic [3:0] s, input logic [3:0] d, input int stall);
    check({nm, "_nrd"}, 32'(n_rd - rb), 32'd4);
    check({nm, "_nwr"}, 32'(n_wr - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_rd%0d_addr", nm, i), 32'(rd_a[rb+i]), 32'(4'(s + i)));
      check($sformatf("%s_rd%0d_cyc", nm, i), 32'(rd_c[rb+i]), 32'(i + 1));
      check($sformatf("%s_wr%0d_addr", nm, i), 32'(wr_a[wb+i]), 32'(4'(d + i)));
      check($sformatf("%s_wr%0d_data", nm, i), wr_d[wb+i], xpose[i]);
      check($sformatf("%s_wr%0d_cyc", nm, i), 32'(wr_c[wb+i]), 32'(6 + i + ((i >= 1) ? stall : 0)));
      check($sformatf("%s_mem%0d", nm, i), mem[4'(d + i)], xpose[i]);
    end
    check({nm, "_done_cyc"}, 32'(done_c[db]), 32'(10 + stall));
    check({nm, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
    check({nm, "_rd_en"}, 32'(rf_rd_en), 32'd0);
    check({nm, "_rd_addr"}, 32'(rf_rd_addr), 32'd0);
    check({nm, "_wr_en"}, 32'(rf_wr_en), 32'd0);
    check({nm, "_wr_addr"}, 32'(rf_wr_addr), 32'd0);
    check({nm, "_wr_data"}, rf_wr_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; rf_wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");

    // basic: src 0, dst 8
    load_rows(4'd0);
    launch(4'd0, 4'd8);
    wait_done("basic");
    verify("basic", 4'd0, 4'd8, 0);

    // in place
    load_rows(4'd0);
    launch(4'd0, 4'd0);
    wait_done("inplace");
    verify("inplace", 4'd0, 4'd0, 0);

    // write stall on the second write
    load_rows(4'd0);
    launch(4'd0, 4'd8);
    for (int i = 0; i < 20 && !(rf_wr_en && rf_wr_addr == 4'd9); i++) @(negedge clk);
    rf_wr_ready = 1'b0;
    @(negedge clk);
    check("stall_hold_addr", 32'(rf_wr_addr), 32'd9);
    check("stall_hold_data", rf_wr_data, 32'h5b747453);
    @(negedge clk);
    check("stall_hold_addr2", 32'(rf_wr_addr), 32'd9);
    rf_wr_ready = 1'b1;
    wait_done("stall");
    verify("stall", 4'd0, 4'd8, 2);

    // address wrap
    load_rows(4'd14);
    launch(4'd14, 4'd15);
    wait_done("wrap");
    verify("wrap", 4'd14, 4'd15, 0);

    // start during READ and during DONE is ignored
    load_rows(4'd0);
    launch(4'd0, 4'd8);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; src_base = 4'd5; dst_base = 4'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("ign_done_level", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("ign_ndone", 32'(n_done - db), 32'd1);
    check("ign_nrd", 32'(n_rd - rb), 32'd4);
    check("ign_nwr", 32'(n_wr - wb), 32'd4);
    check("ign_busy", 32'(busy), 32'd0);

    // reset during the second write cycle
    load(4'd8, 32'h0);
    load(4'd9, 32'h0);
    load_rows(4'd0);
    launch(4'd0, 4'd8);
    for (int i = 0; i < 20 && !(rf_wr_en && rf_wr_addr == 4'd9); i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("abort");
    repeat (12) @(negedge clk);
    check("abort_nwr", 32'(n_wr - wb), 32'd1);
    check("abort_wr0_addr", 32'(wr_a[wb]), 32'd8);
    check("abort_ndone", 32'(n_done - db), 32'd0);
    check("abort_mem8", mem[8], xpose[0]);
    check("abort_mem9", mem[9], 32'h0);
    check("abort_busy", 32'(busy), 32'd0);

    check("rd_wr_overlap", 32'(n_overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
